// File: rtl/spi_slave_decoder.sv
// spi_slave_decoder: oversampled SPI receive decoder reassembling CMD/ADDR/DUMMY/DATA frames.
// Emits one registered transaction per frame; CS rise mid-frame aborts and drops partial data.
module spi_slave_decoder #(
   parameter int SYNC_STAGES = 2,
   parameter int DUMMY_REG   = 1,
   parameter int DUMMY_MEM   = 34,
   parameter int CNT_W       = 16
) (
   input  logic             clk_sys_i,
   input  logic             rst_ni,
   input  logic             spi_sclk_i,
   input  logic             spi_sdi_i,
   input  logic             spi_cs_i,
   output logic             txn_valid_o,
   output logic [7:0]       txn_cmd_o,
   output logic [31:0]      txn_addr_o,
   output logic [31:0]      txn_data_o,
   output logic             txn_abort_o,
   output logic [CNT_W-1:0] txn_count_o,
   output logic             busy_o
);
   typedef enum logic [2:0] {S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_DATA} state_e;
   localparam logic [7:0] OP_WREG = 8'h01;
   localparam logic [7:0] OP_RREG = 8'h07;
   localparam logic [7:0] OP_RMEM = 8'h0B;
   localparam logic [5:0] DREG_L  = 6'(DUMMY_REG - 1);
   localparam logic [5:0] DMEM_L  = 6'(DUMMY_MEM - 1);
   logic [SYNC_STAGES-1:0] sclk_sync_q, sdi_sync_q, cs_sync_q;
   logic                   sclk_q;
   state_e                 st_q, st_d;
   logic [5:0]             cnt_q, cnt_d;
   logic [31:0]            sh_q, sh_d;
   logic [7:0]             op_q, op_d;
   logic [31:0]            ad_q, ad_d;
   logic [31:0]            dat_q, dat_d;
   logic                   pend_q, pend_d;
   logic                   valid_q, valid_d;
   logic                   abort_q, abort_d;
   logic [7:0]             cmd_q, cmd_d;
   logic [31:0]            addr_q, addr_d;
   logic [31:0]            data_q, data_d;
   logic [CNT_W-1:0]       count_q, count_d;
   logic                   sclk_s, sdi_s, cs_s, sclk_rise, busy;
   logic [31:0]            sh_nx;
   logic [5:0]             last_idx;
   assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
   assign sdi_s     = sdi_sync_q[SYNC_STAGES-1];
   assign cs_s      = cs_sync_q[SYNC_STAGES-1];
   assign sclk_rise = sclk_s & ~sclk_q;
   assign sh_nx     = {sh_q[30:0], sdi_s};
   assign busy      = (st_q != S_IDLE) && ((st_q != S_CMD) || (cnt_q != 6'd0));
   // Index of the final bit of the current phase
   assign last_idx  = (st_q == S_CMD)   ? 6'd7 :
                      (st_q == S_ADDR)  ? 6'd31 :
                      (st_q == S_DUMMY) ? ((op_q == OP_RMEM) ? DMEM_L : DREG_L) :
                      (op_q == OP_WREG) ? 6'd7 : 6'd31;
   always_ff @(posedge clk_sys_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sclk_sync_q <= '0;
         sdi_sync_q  <= '0;
         cs_sync_q   <= '0;
         sclk_q      <= 1'b0;
         st_q        <= S_IDLE;
         cnt_q       <= '0;
         sh_q        <= '0;
         op_q        <= '0;
         ad_q        <= '0;
         dat_q       <= '0;
         pend_q      <= 1'b0;
         valid_q     <= 1'b0;
         abort_q     <= 1'b0;
         cmd_q       <= '0;
         addr_q      <= '0;
         data_q      <= '0;
         count_q     <= '0;
      end else begin
         sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk_i};
         sdi_sync_q  <= {sdi_sync_q[SYNC_STAGES-2:0], spi_sdi_i};
         cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs_i};
         sclk_q      <= sclk_s;
         st_q        <= st_d;
         cnt_q       <= cnt_d;
         sh_q        <= sh_d;
         op_q        <= op_d;
         ad_q        <= ad_d;
         dat_q       <= dat_d;
         pend_q      <= pend_d;
         valid_q     <= valid_d;
         abort_q     <= abort_d;
         cmd_q       <= cmd_d;
         addr_q      <= addr_d;
         data_q      <= data_d;
         count_q     <= count_d;
      end
   end
   always_comb begin
      st_d    = st_q;
      cnt_d   = cnt_q;
      sh_d    = sh_q;
      op_d    = op_q;
      ad_d    = ad_q;
      dat_d   = dat_q;
      pend_d  = 1'b0;
      abort_d = 1'b0;
      valid_d = pend_q;
      cmd_d   = pend_q ? op_q : cmd_q;
      addr_d  = pend_q ? ad_q : addr_q;
      data_d  = pend_q ? dat_q : data_q;
      count_d = pend_q ? count_q + 1'b1 : count_q;
      if (st_q == S_IDLE) begin
         if (!cs_s) begin
            st_d  = S_CMD;
            cnt_d = '0;
         end
      end else if (cs_s) begin
         // CS wins over a coincident SCLK edge; the bit is dropped
         st_d    = S_IDLE;
         cnt_d   = '0;
         abort_d = busy;
      end else if (sclk_rise) begin
         sh_d  = sh_nx;
         cnt_d = cnt_q + 6'd1;
         if (cnt_q == last_idx) begin
            cnt_d = '0;
            if (st_q == S_CMD) begin
               op_d = sh_nx[7:0];
               ad_d = '0;
               st_d = (sh_nx[7:0] == OP_WREG) ? S_DATA :
                      (sh_nx[7:0] == OP_RREG) ? ((DUMMY_REG == 0) ? S_DATA : S_DUMMY) : S_ADDR;
            end else if (st_q == S_ADDR) begin
               ad_d = sh_nx;
               st_d = ((op_q == OP_RMEM) && (DUMMY_MEM != 0)) ? S_DUMMY : S_DATA;
            end else if (st_q == S_DUMMY) begin
               st_d = S_DATA;
            end else begin
               dat_d  = (op_q == OP_WREG) ? {24'h0, sh_nx[7:0]} : sh_nx;
               pend_d = 1'b1;
               st_d   = S_CMD;
            end
         end
      end
   end
   assign txn_valid_o = valid_q;
   assign txn_cmd_o   = cmd_q;
   assign txn_addr_o  = addr_q;
   assign txn_data_o  = data_q;
   assign txn_abort_o = abort_q;
   assign txn_count_o = count_q;
   assign busy_o      = busy;
endmodule

// File: tb/tb_spi_slave_decoder.sv
// tb_spi_slave_decoder: directed SPI frames with a scoreboard of expected transactions.
module tb_spi_slave_decoder;
   typedef struct {
      logic [7:0]  c;
      logic [31:0] a;
      logic [31:0] d;
      logic [15:0] n;
   } exp_t;
   logic        clk = 1'b0;
   logic        rst_n, sclk, sdi, cs;
   logic        valid, abort, busy;
   logic [7:0]  cmd;
   logic [31:0] addr, data;
   logic [15:0] count;
   exp_t        q[$];
   int          errors = 0, checks = 0, n_valid = 0, n_abort = 0;
   spi_slave_decoder dut (
      .clk_sys_i(clk), .rst_ni(rst_n), .spi_sclk_i(sclk), .spi_sdi_i(sdi), .spi_cs_i(cs),
      .txn_valid_o(valid), .txn_cmd_o(cmd), .txn_addr_o(addr), .txn_data_o(data),
      .txn_abort_o(abort), .txn_count_o(count), .busy_o(busy)
   );
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, got, exp);
      end
   endtask
   // Scoreboard consumer: every valid pulse must match the oldest expected transaction
   always @(negedge clk) begin
      if (rst_n) begin
         if (valid) begin
            n_valid++;
            check("valid_and_abort", {31'd0, abort}, 32'd0);
            check("sb_nonempty", {31'd0, q.size() != 0}, 32'd1);
            if (q.size() != 0) begin
               exp_t e;
               e = q.pop_front();
               check("txn_cmd", {24'd0, cmd}, {24'd0, e.c});
               check("txn_addr", addr, e.a);
               check("txn_data", data, e.d);
               check("txn_count", {16'd0, count}, {16'd0, e.n});
            end
         end
         if (abort) n_abort++;
      end
   end
   task automatic bit_out(input logic b);
      sdi = b;
      repeat (4) @(negedge clk);
      sclk = 1'b1;
      repeat (4) @(negedge clk);
      sclk = 1'b0;
   endtask
   task automatic send(input logic [31:0] v, input int n);
      for (int i = n - 1; i >= 0; i--) bit_out(v[i]);
   endtask
   task automatic cs_low();
      cs = 1'b0;
      repeat (4) @(negedge clk);
   endtask
   task automatic cs_high();
      repeat (4) @(negedge clk);
      cs = 1'b1;
      repeat (8) @(negedge clk);
   endtask
   task automatic push(input logic [7:0] c, input logic [31:0] a, input logic [31:0] d, input logic [15:0] n);
      exp_t e;
      e.c = c; e.a = a; e.d = d; e.n = n;
      q.push_back(e);
   endtask
   task automatic check_reset_outputs();
      check("rst_valid", {31'd0, valid}, 32'd0);
      check("rst_cmd", {24'd0, cmd}, 32'd0);
      check("rst_addr", addr, 32'd0);
      check("rst_data", data, 32'd0);
      check("rst_abort", {31'd0, abort}, 32'd0);
      check("rst_count", {16'd0, count}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
   endtask
   initial begin
      int nv, na;
      rst_n = 1'b0; cs = 1'b1; sclk = 1'b0; sdi = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_outputs();
      rst_n = 1'b1;
      repeat (8) @(negedge clk);
      // write-mem
      push(8'h02, 32'h1000_0040, 32'hDEAD_BEEF, 16'd1);
      cs_low();
      send(32'h02, 8); send(32'h1000_0040, 32); send(32'hDEAD_BEEF, 32);
      cs_high();
      check("wmem_nvalid", n_valid, 1);
      check("wmem_noabort", n_abort, 0);
      check("wmem_busy_idle", {31'd0, busy}, 32'd0);
      // write-reg
      push(8'h01, 32'h0, 32'h0000_00A5, 16'd2);
      cs_low();
      send(32'h01, 8); send(32'hA5, 8);
      cs_high();
      check("wreg_nvalid", n_valid, 2);
      // read-mem with exact latency on the final SCLK edge
      push(8'h0B, 32'h2000_0000, 32'h1234_5678, 16'd3);
      cs_low();
      send(32'h0B, 8); send(32'h2000_0000, 32); send(32'h0, 32); send(32'h0, 2);
      send(32'h1234_5678 >> 1, 31);
      sdi = 1'b0;
      repeat (4) @(negedge clk);
      sclk = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check("rmem_early_valid", {31'd0, valid}, 32'd0);
      end
      @(negedge clk);
      check("rmem_latency_valid", {31'd0, valid}, 32'd1);
      repeat (3) @(negedge clk);
      sclk = 1'b0;
      cs_high();
      check("rmem_nvalid", n_valid, 3);
      // back-to-back under one CS low
      push(8'h01, 32'h0, 32'h0000_005A, 16'd4);
      push(8'h03, 32'hCAFE_0004, 32'h0BAD_F00D, 16'd5);
      push(8'h07, 32'h0, 32'h8000_0001, 16'd6);
      cs_low();
      send(32'h01, 8); send(32'h5A, 8);
      check("b2b_busy1", {31'd0, busy}, 32'd0);
      send(32'h03, 8); send(32'hCAFE_0004, 32); send(32'h0BAD_F00D, 32);
      check("b2b_busy2", {31'd0, busy}, 32'd0);
      send(32'h07, 8); send(32'h1, 1);
      check("b2b_busy_dummy", {31'd0, busy}, 32'd1);
      send(32'h8000_0001, 32);
      check("b2b_busy3", {31'd0, busy}, 32'd0);
      cs_high();
      check("b2b_nvalid", n_valid, 6);
      check("b2b_noabort", n_abort, 0);
      // abort after 20 ADDR bits
      nv = n_valid; na = n_abort;
      cs_low();
      send(32'h02, 8); send(32'hFFFFF, 20);
      check("abort_busy", {31'd0, busy}, 32'd1);
      cs_high();
      check("abort_pulse", n_abort - na, 1);
      check("abort_novalid", n_valid - nv, 0);
      check("abort_count", {16'd0, count}, 32'd6);
      check("abort_busy_after", {31'd0, busy}, 32'd0);
      push(8'h0C, 32'h0000_1234, 32'h5555_AAAA, 16'd7);
      cs_low();
      send(32'h0C, 8); send(32'h0000_1234, 32); send(32'h5555_AAAA, 32);
      cs_high();
      check("post_abort_nvalid", n_valid, 7);
      // async reset mid-DATA
      cs_low();
      send(32'h02, 8); send(32'h1111_2222, 32); send(32'hFFFF, 16);
      check("pre_rst_busy", {31'd0, busy}, 32'd1);
      #2 rst_n = 1'b0;
      #1 check_reset_outputs();
      cs = 1'b1;
      repeat (4) @(negedge clk);
      rst_n = 1'b1;
      repeat (8) @(negedge clk);
      push(8'h02, 32'h0000_0F00, 32'h7654_3210, 16'd1);
      cs_low();
      send(32'h02, 8); send(32'h0000_0F00, 32); send(32'h7654_3210, 32);
      cs_high();
      check("post_rst_nvalid", n_valid, 8);
      check("sb_drained", q.size(), 0);
      check("total_abort", n_abort, 1);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
